dram_ctrl: RTL and testbench
============================

# dram_ctrl

Initiator-side controller for the single-port on-chip data RAM (`DRAM`: `clock`, `address`, `wren`, `data`, `q`). It converts processor load/store requests, arriving on a valid/ready handshake, into cycle-accurate RAM port activity: single-word writes and incrementing burst reads. It also returns read data on a response strobe, hiding the RAM's registered read latency from the core. It sits between the processor datapath and `DRAM`, and is the only driver of the RAM port.

## Interface
Parameters:
- `AW`, 8, address width; must match `DRAM` address.
- `DW`, 8, data width; must match `DRAM` data/q.
- `RD_LAT`, 2, cycles from address presented on `mem_address` to `rsp_valid`. Valid range is 2..4.

Ports:
- `clock`  in  1  single system clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  start address.
- `req_wdata`  in  DW  write data; ignored for reads.
- `req_len`  in  8  read burst length minus 1 (0 = one word); ignored for writes.
- `rsp_valid`  out  1  one read word on `rsp_data` this cycle.
- `rsp_data`  out  DW  read data.
- `rsp_last`  out  1  final word of the burst; qualified by `rsp_valid`.
- `busy`  out  1  high in any state other than IDLE, or while read tags are in flight.
- `mem_address`  out  AW  to `DRAM.address`.
- `mem_wren`  out  1  to `DRAM.wren`.
- `mem_data`  out  DW  to `DRAM.data`.
- `mem_q`  in  DW  from `DRAM.q`.

## Operation
- States are IDLE, WRITE, READ, DRAIN.
- `req_ready` = 1 only in IDLE with the read tag pipeline empty. A request is accepted on a rising edge with `req_valid && req_ready`.
- IDLE, write accepted: latch addr/wdata and go to WRITE.
  - In WRITE, `mem_address`=addr, `mem_data`=wdata and `mem_wren`=1 for exactly one cycle, then return to IDLE.
  - Writes produce no response.
- IDLE, read accepted: load the address counter with `req_addr` and the remaining count with `req_len`, then go to READ.
  - In READ, present one address per cycle: `mem_address` = start+i for i = 0..len, with `mem_wren`=0.
  - After the address with count 0 is presented, go to DRAIN.
- Address arithmetic is modulo 2^AW: 0xFF+1 wraps to 0x00. There is no error.
- Tag pipeline:
  - A shift register of depth RD_LAT carries {valid, last} per presented read address.
  - `mem_q` is captured into `rsp_data` on the edge where the tag reaches the final stage.
  - `rsp_valid`/`rsp_last` are driven from that final stage.
- DRAIN: hold `mem_wren`=0 until the pipeline is empty, then go to IDLE.
- `rsp_*` has no backpressure. The consumer must accept every word.
- `mem_address`/`mem_data` hold their last value when not actively driven. `mem_wren` is 0 in every state except WRITE.
- `req_len`/`req_addr` changes after acceptance are ignored.

## Timing
- Reset (asynchronous assert, synchronous release at next edge):
  - State returns to IDLE and all tags are cleared.
  - `req_ready`=1 after release; `busy`=0.
  - `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0.
  - `mem_address`=0, `mem_wren`=0, `mem_data`=0.
- Reset mid-burst discards all outstanding reads. No `rsp_valid` appears after release.
- Write accepted at edge E: `mem_wren`=1 during cycle E+1 only. `req_ready` is 0 in cycle E+1 and 1 again in cycle E+2.
- Read accepted at edge E:
  - Word i is presented on `mem_address` in cycle E+1+i.
  - The matching `rsp_valid` is asserted in cycle E+1+i+RD_LAT.
  - Responses are contiguous: len+1 consecutive cycles. `rsp_last` is set on the final one.
- `req_ready` returns to 1 in the cycle after the last `rsp_valid`. Read-to-next-request turnaround therefore includes the full drain, so the bench need not handle overlapping bursts.
- `req_valid` held high while `req_ready`=0 is ignored. The request is accepted at the first edge where ready is 1.

## Test plan
- Reset: assert `reset_n`=0 mid-run, check all outputs match the reset values above. Release and check `req_ready`=1, `busy`=0.
- Single write: addr 0x10, wdata 0xA5. Expect `mem_wren`=1 for one cycle with `mem_address`=0x10 and `mem_data`=0xA5, and no `rsp_valid`.
- Single read:
  - Preload 0x10=0xA5.
  - Read 0x10 with len 0.
  - Expect one `rsp_valid` with `rsp_data`=0xA5 and `rsp_last`=1, exactly RD_LAT+1 cycles after the accept edge.
- Wrapping burst:
  - Preload 0xFE..0x01 with 0x11, 0x22, 0x33, 0x44.
  - Read 0xFE with len 3.
  - Expect addresses 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles.
  - Expect 4 contiguous responses 0x11..0x44, with `rsp_last` only on 0x44.
- Back-pressure on requests: hold `req_valid`=1 with a write queued behind a len 7 read. Expect `req_ready`=0 until the cycle after the 8th response, and the write accepted only then.
- Reset mid-burst: start a len 15 read and pull `reset_n` low after 5 responses. Expect zero further `rsp_valid`, and a fresh single read working normally afterwards.

Source files
------------

// File: rtl/dram_ctrl.sv
// dram_ctrl -- initiator-side controller for the single-port on-chip data RAM.
//
// Turns processor load/store requests (valid/ready) into RAM port activity:
// single-word writes and incrementing burst reads, and returns read words on
// a response strobe so the core never sees the RAM's registered read latency.
// This block is the only driver of the RAM port.
//
// Parameters
//   AW      address width (matches DRAM address)
//   DW      data width (matches DRAM data/q)
//   RD_LAT  cycles from an address on mem_address to its rsp_valid, 2..4
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset, released synchronously
//   req_valid    request present
//   req_ready    request can be accepted (IDLE and no reads in flight)
//   req_we       1 = write, 0 = read
//   req_addr     start address
//   req_wdata    write data (ignored for reads)
//   req_len      read burst length minus 1 (ignored for writes)
//   rsp_valid    one read word on rsp_data this cycle
//   rsp_data     read data
//   rsp_last     final word of the burst, qualified by rsp_valid
//   busy         not IDLE, or read tags still in flight
//   mem_address  to DRAM.address
//   mem_wren     to DRAM.wren
//   mem_data     to DRAM.data
//   mem_q        from DRAM.q

module dram_ctrl #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [7:0]    req_len,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic          mem_wren,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_reg;
  logic [7:0]    count_reg;
  logic [AW-1:0] mem_address_reg;
  logic [DW-1:0] mem_data_reg;
  logic          mem_wren_reg;

  // Stage 0 of the tag pipeline is written by the FSM in the same edge that
  // puts the matching address on mem_address, so the tag and the address
  // travel together from the very first cycle.
  logic          issue_valid_reg;
  logic          issue_last_reg;

  // Stages 1 .. RD_LAT-1; the response registers form the final stage.
  logic          tag_valid_reg [1:RD_LAT-1];
  logic          tag_last_reg  [1:RD_LAT-1];

  logic          rsp_valid_reg;
  logic          rsp_last_reg;
  logic [DW-1:0] rsp_data_reg;

  logic          tags_any;
  logic          accept;

  always_comb begin
    tags_any = issue_valid_reg;
    for (int k = 1; k < RD_LAT; k++) begin
      tags_any = tags_any | tag_valid_reg[k];
    end
  end

  assign req_ready   = (state_reg == IDLE) && !tags_any;
  assign busy        = (state_reg != IDLE) || tags_any;
  assign accept      = req_valid && req_ready;

  assign mem_address = mem_address_reg;
  assign mem_data    = mem_data_reg;
  assign mem_wren    = mem_wren_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_last    = rsp_last_reg;
  assign rsp_data    = rsp_data_reg;

  // Control FSM with registered RAM-port outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      count_reg       <= 8'd0;
      mem_address_reg <= '0;
      mem_data_reg    <= '0;
      mem_wren_reg    <= 1'b0;
      issue_valid_reg <= 1'b0;
      issue_last_reg  <= 1'b0;
    end else begin
      // Write strobe and tag issue are single-cycle pulses unless re-armed.
      mem_wren_reg    <= 1'b0;
      issue_valid_reg <= 1'b0;
      issue_last_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mem_address_reg <= req_addr;
            if (req_we) begin
              mem_data_reg <= req_wdata;
              mem_wren_reg <= 1'b1;
              state_reg    <= WRITE;
            end else begin
              count_reg       <= req_len;
              issue_valid_reg <= 1'b1;
              issue_last_reg  <= (req_len == 8'd0);
              state_reg       <= READ;
            end
          end
        end
        WRITE: begin
          state_reg <= IDLE;
        end
        READ: begin
          // The address with count 0 is on the port this cycle: stop issuing.
          if (count_reg == 8'd0) begin
            state_reg <= DRAIN;
          end else begin
            mem_address_reg <= mem_address_reg + AW'(1);  // wraps modulo 2^AW
            count_reg       <= count_reg - 8'd1;
            issue_valid_reg <= 1'b1;
            issue_last_reg  <= (count_reg == 8'd1);
          end
        end
        DRAIN: begin
          if (!tags_any) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Tag shift register: one {valid, last} per presented read address.
  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag
    if (gi == 1) begin : g_first
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_last_reg[gi]  <= 1'b0;
        end else begin
          tag_valid_reg[gi] <= issue_valid_reg;
          tag_last_reg[gi]  <= issue_last_reg;
        end
      end
    end else begin : g_rest
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_last_reg[gi]  <= 1'b0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_last_reg[gi]  <= tag_last_reg[gi-1];
        end
      end
    end
  end

  // Final stage: mem_q is sampled on the edge the tag leaves the pipeline,
  // which is exactly when the RAM has the matching word on q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_last_reg  <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= tag_valid_reg[RD_LAT-1];
      rsp_last_reg  <= tag_valid_reg[RD_LAT-1] && tag_last_reg[RD_LAT-1];
      if (tag_valid_reg[RD_LAT-1]) begin
        rsp_data_reg <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl -- directed self-checking bench for dram_ctrl with a behavioural
// single-port RAM (registered address, q valid the following cycle).

module tb_dram_ctrl;

  localparam int RD_LAT = 2;
  localparam int HN     = 1024;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] req_len;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       busy;
  logic [7:0] mem_address;
  logic       mem_wren;
  logic [7:0] mem_data;
  logic [7:0] mem_q;

  always #5 clock = ~clock;

  dram_ctrl #(.AW(8), .DW(8), .RD_LAT(RD_LAT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_len    (req_len),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .busy       (busy),
    .mem_address(mem_address),
    .mem_wren   (mem_wren),
    .mem_data   (mem_data),
    .mem_q      (mem_q)
  );

  // Behavioural DRAM.
  logic [7:0] ram [0:255];
  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  // Cycle counter and per-cycle history of the DUT outputs (sampled mid-cycle).
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] addr_h  [0:HN-1];
  logic [7:0] data_h  [0:HN-1];
  logic [7:0] rd_h    [0:HN-1];
  logic       wren_h  [0:HN-1];
  logic       rv_h    [0:HN-1];
  logic       rl_h    [0:HN-1];
  logic       ready_h [0:HN-1];

  always @(negedge clock) begin
    if (cyc < HN) begin
      addr_h[cyc]  <= mem_address;
      data_h[cyc]  <= mem_data;
      rd_h[cyc]    <= rsp_data;
      wren_h[cyc]  <= mem_wren;
      rv_h[cyc]    <= rsp_valid;
      rl_h[cyc]    <= rsp_last;
      ready_h[cyc] <= req_ready;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic int count_rv(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) if (rv_h[k]) s++;
    return s;
  endfunction

  function automatic int count_wr(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) if (wren_h[k]) s++;
    return s;
  endfunction

  // Present a request at a negedge and hold it until accepted. Returns the
  // cycle index of the first cycle after the accepting edge.
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] len, output int acc);
    int waited = 0;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_len   = len;
    req_valid = 1'b1;
    while (!req_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) check_eq("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    acc = cyc;
    @(negedge clock);
    req_valid = 1'b0;
    $display("req  we=%0d addr=0x%02h wdata=0x%02h len=%0d accepted, first cycle %0d",
             we, a, d, len, acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  logic [7:0] wrap_addr [0:3];
  logic [7:0] wrap_data [0:3];

  initial begin
    int e, w, r, dummy;
    wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFF; wrap_addr[2] = 8'h00; wrap_addr[3] = 8'h01;
    wrap_data[0] = 8'h11; wrap_data[1] = 8'h22; wrap_data[2] = 8'h33; wrap_data[3] = 8'h44;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    req_len   = 8'h00;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check_eq("init_ready", 32'(req_ready), 32'd1);
    check_eq("init_busy",  32'(busy),      32'd0);

    // Reset asserted asynchronously in the middle of a write cycle.
    send(1'b1, 8'h77, 8'h33, 8'h00, e);
    check_eq("pre_rst_wren", 32'(mem_wren), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mem_wren",    32'(mem_wren),    32'd0);
    check_eq("rst_mem_address", 32'(mem_address), 32'h00);
    check_eq("rst_mem_data",    32'(mem_data),    32'h00);
    check_eq("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check_eq("rst_rsp_last",    32'(rsp_last),    32'd0);
    check_eq("rst_rsp_data",    32'(rsp_data),    32'h00);
    check_eq("rst_busy",        32'(busy),        32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check_eq("rel_ready", 32'(req_ready), 32'd1);
    check_eq("rel_busy",  32'(busy),      32'd0);

    // Single write 0x10 <= 0xA5.
    send(1'b1, 8'h10, 8'hA5, 8'h00, e);
    tick(6);
    check_eq("wr_wren",      32'(wren_h[e]),        32'd1);
    check_eq("wr_addr",      32'(addr_h[e]),        32'h10);
    check_eq("wr_data",      32'(data_h[e]),        32'hA5);
    check_eq("wr_one_cycle", 32'(count_wr(e, e+5)), 32'd1);
    check_eq("wr_ready_e1",  32'(ready_h[e]),       32'd0);
    check_eq("wr_ready_e2",  32'(ready_h[e+1]),     32'd1);
    check_eq("wr_no_rsp",    32'(count_rv(e, e+5)), 32'd0);

    // Single read of 0x10, len 0.
    send(1'b0, 8'h10, 8'h00, 8'h00, e);
    tick(8);
    check_eq("rd1_addr",     32'(addr_h[e]),          32'h10);
    check_eq("rd1_wren",     32'(wren_h[e]),          32'd0);
    check_eq("rd1_valid",    32'(rv_h[e+RD_LAT]),     32'd1);
    check_eq("rd1_data",     32'(rd_h[e+RD_LAT]),     32'hA5);
    check_eq("rd1_last",     32'(rl_h[e+RD_LAT]),     32'd1);
    check_eq("rd1_count",    32'(count_rv(e, e+7)),   32'd1);
    check_eq("rd1_ready_lo", 32'(ready_h[e+RD_LAT]),  32'd0);
    check_eq("rd1_ready_hi", 32'(ready_h[e+RD_LAT+1]), 32'd1);

    // Wrapping burst 0xFE..0x01.
    for (int i = 0; i < 4; i++) send(1'b1, wrap_addr[i], wrap_data[i], 8'h00, dummy);
    send(1'b0, 8'hFE, 8'h00, 8'd3, e);
    tick(10);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("wrap_addr%0d", i),  32'(addr_h[e+i]),         32'(wrap_addr[i]));
      check_eq($sformatf("wrap_valid%0d", i), 32'(rv_h[e+RD_LAT+i]),    32'd1);
      check_eq($sformatf("wrap_data%0d", i),  32'(rd_h[e+RD_LAT+i]),    32'(wrap_data[i]));
      check_eq($sformatf("wrap_last%0d", i),  32'(rl_h[e+RD_LAT+i]),    (i == 3) ? 32'd1 : 32'd0);
    end
    check_eq("wrap_count",    32'(count_rv(e, e+9)), 32'd4);
    check_eq("wrap_ready_lo", 32'(ready_h[e+5]),     32'd0);
    check_eq("wrap_ready_hi", 32'(ready_h[e+6]),     32'd1);

    // Request back-pressure: write held behind a len 7 read.
    for (int i = 0; i < 8; i++) send(1'b1, 8'(8'h40 + i), 8'(8'h80 + i), 8'h00, dummy);
    send(1'b0, 8'h40, 8'h00, 8'd7, e);
    send(1'b1, 8'h90, 8'h5C, 8'h00, w);
    tick(3);
    check_eq("bp_accept_cycle", 32'(w - e),               32'd11);
    check_eq("bp_wren",         32'(wren_h[w]),           32'd1);
    check_eq("bp_waddr",        32'(addr_h[w]),           32'h90);
    check_eq("bp_no_early_wr",  32'(count_wr(e, w-1)),    32'd0);
    check_eq("bp_ready_last",   32'(ready_h[e+9]),        32'd0);
    check_eq("bp_ready_after",  32'(ready_h[e+10]),       32'd1);
    check_eq("bp_rsp_count",    32'(count_rv(e+2, e+9)),  32'd8);
    check_eq("bp_data7",        32'(rd_h[e+9]),           32'h87);
    check_eq("bp_last7",        32'(rl_h[e+9]),           32'd1);
    check_eq("bp_last6",        32'(rl_h[e+8]),           32'd0);

    // Reset in the middle of a len 15 burst, after 5 responses.
    send(1'b0, 8'h40, 8'h00, 8'd15, e);
    tick(7);
    #1 reset_n = 1'b0;
    #1;
    r = cyc;
    check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_data",  32'(rsp_data),  32'h00);
    check_eq("mid_rst_busy",  32'(busy),      32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    check_eq("mid_pre_count",  32'(count_rv(e, e+6)),    32'd5);
    check_eq("mid_data4",      32'(rd_h[e+6]),           32'h84);
    check_eq("mid_post_count", 32'(count_rv(r+1, r+21)), 32'd0);
    check_eq("mid_post_ready", 32'(req_ready),           32'd1);

    // Fresh read after the reset: picks up the write accepted under back-pressure.
    send(1'b0, 8'h90, 8'h00, 8'h00, e);
    tick(6);
    check_eq("post_valid", 32'(rv_h[e+RD_LAT]),   32'd1);
    check_eq("post_data",  32'(rd_h[e+RD_LAT]),   32'h5C);
    check_eq("post_last",  32'(rl_h[e+RD_LAT]),   32'd1);
    check_eq("post_count", 32'(count_rv(e, e+5)), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
